// File: rtl/serial_to_parallel_if.sv
// Handshake/data bundle between a serial bit source and the deserializer.
// master drives the serial side and ACK; slave is the deserializer.
interface serial_to_parallel_if #(
  parameter int DEPTH = 3
);
  logic             data;
  logic             shift_en;
  logic             clear;
  logic             ack;
  logic [DEPTH-1:0] data_out;
  logic             valid;
  logic             busy;
  logic             overrun;

  modport master (
    output data, shift_en, clear, ack,
    input  data_out, valid, busy, overrun
  );

  modport slave (
    input  data, shift_en, clear, ack,
    output data_out, valid, busy, overrun
  );
endinterface

// File: rtl/serial_to_parallel.sv
// LSB-first serial-in, parallel-out deserializer with a held output word,
// VALID/ACK handshake and a sticky overrun flag.
module serial_to_parallel #(
  parameter int DEPTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_to_parallel_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

  logic [DEPTH-1:0] sr;
  logic [CNT_W-1:0] cnt;
  logic [DEPTH-1:0] data_out_q;
  logic             valid_q;
  logic             overrun_q;
  logic [DEPTH-1:0] shifted;
  logic             complete;

  // New bits enter at the top, so the first bit received ends up in bit 0.
  assign shifted  = {bus.data, sr[DEPTH-1:1]};
  assign complete = bus.shift_en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr         <= '0;
      cnt        <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else if (bus.clear) begin
      sr         <= '0;
      cnt        <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else if (complete) begin
      // A completing word wins over ACK; ACK only covers the word it replaces.
      data_out_q <= shifted;
      sr         <= '0;
      cnt        <= '0;
      valid_q    <= 1'b1;
      if (valid_q && !bus.ack) overrun_q <= 1'b1;
    end else begin
      if (bus.shift_en) begin
        sr  <= shifted;
        cnt <= cnt + CNT_W'(1);
      end
      if (valid_q && bus.ack) valid_q <= 1'b0;
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.valid    = valid_q;
  assign bus.overrun  = overrun_q;
  assign bus.busy     = (cnt != '0);

endmodule

// File: tb/tb_serial_to_parallel.sv
// Directed bench for serial_to_parallel with DEPTH = 3.
module tb_serial_to_parallel;
  localparam int DEPTH = 3;

  logic clk;
  logic rst_n;
  int   vectors;
  int   errors;

  serial_to_parallel_if #(.DEPTH(DEPTH)) bus ();

  serial_to_parallel #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.shift_en = 1'b1;
    bus.data     = b;
    step();
    bus.shift_en = 1'b0;
  endtask

  task automatic idle2();
    for (int i = 0; i < 2; i++) begin
      bus.data = ~bus.data;
      step();
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] d, input logic v,
                           input logic b, input logic o);
    check({tag, ".data_out"}, 8'(bus.data_out), 8'(d));
    check({tag, ".valid"},    8'(bus.valid),    8'(v));
    check({tag, ".busy"},     8'(bus.busy),     8'(b));
    check({tag, ".overrun"},  8'(bus.overrun),  8'(o));
  endtask

  initial begin
    vectors      = 0;
    errors       = 0;
    rst_n        = 1'b0;
    bus.clear    = 1'b0;
    bus.ack      = 1'b0;
    bus.data     = 1'($urandom);
    bus.shift_en = 1'b1;

    // Reset held with random serial activity
    for (int i = 0; i < 3; i++) begin
      bus.data     = 1'($urandom);
      bus.shift_en = 1'($urandom);
      step();
    end
    check_all("reset", 3'b000, 1'b0, 1'b0, 1'b0);
    bus.shift_en = 1'b0;
    #2 rst_n = 1'b1;

    // ACK with nothing pending
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    check("ack_idle.valid", 8'(bus.valid), 8'd0);

    // Continuous receive 1,1,0
    send_bit(1'b1);
    check("cont1.busy",  8'(bus.busy),  8'd1);
    check("cont1.valid", 8'(bus.valid), 8'd0);
    bus.shift_en = 1'b1; bus.data = 1'b1;
    step();
    check("cont2.busy",  8'(bus.busy),  8'd1);
    bus.data = 1'b0;
    step();
    bus.shift_en = 1'b0;
    check_all("cont3", 3'b011, 1'b1, 1'b0, 1'b0);
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    check("ack.valid",    8'(bus.valid),    8'd0);
    check("ack.data_out", 8'(bus.data_out), 8'h3);

    // Gapped receive 1,0,1
    send_bit(1'b1);
    idle2();
    check("gap1.valid", 8'(bus.valid), 8'd0);
    check("gap1.busy",  8'(bus.busy),  8'd1);
    send_bit(1'b0);
    idle2();
    check("gap2.valid", 8'(bus.valid), 8'd0);
    send_bit(1'b1);
    check_all("gap3", 3'b101, 1'b1, 1'b0, 1'b0);
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;

    // Overrun then clear
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    check_all("ovr_a", 3'b011, 1'b1, 1'b0, 1'b0);
    send_bit(1'b0); send_bit(1'b1);
    check("ovr_mid.overrun", 8'(bus.overrun), 8'd0);
    send_bit(1'b1);
    check_all("ovr_b", 3'b110, 1'b1, 1'b0, 1'b1);
    step();
    check("ovr_sticky", 8'(bus.overrun), 8'd1);
    send_bit(1'b1);
    bus.clear = 1'b1; bus.shift_en = 1'b1; bus.ack = 1'b1; bus.data = 1'b1;
    step();
    bus.clear = 1'b0; bus.shift_en = 1'b0; bus.ack = 1'b0;
    check_all("clear", 3'b000, 1'b0, 1'b0, 1'b0);

    // ACK coincident with completion
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    check("coin_pend.data_out", 8'(bus.data_out), 8'h3);
    send_bit(1'b1); send_bit(1'b0);
    bus.shift_en = 1'b1; bus.data = 1'b0; bus.ack = 1'b1;
    step();
    bus.shift_en = 1'b0; bus.ack = 1'b0;
    check_all("coin", 3'b001, 1'b1, 1'b0, 1'b0);
    step();
    check("coin_hold.valid", 8'(bus.valid), 8'd1);
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;

    // Back-to-back words at full rate, no ACK
    bus.shift_en = 1'b1;
    bus.data = 1'b1; step();
    bus.data = 1'b0; step();
    bus.data = 1'b0; step();
    check_all("b2b1", 3'b001, 1'b1, 1'b0, 1'b0);
    bus.data = 1'b0; step();
    bus.data = 1'b0; step();
    bus.data = 1'b1; step();
    bus.shift_en = 1'b0;
    check_all("b2b2", 3'b100, 1'b1, 1'b0, 1'b1);
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;

    // Asynchronous reset mid-word
    send_bit(1'b1); send_bit(1'b1);
    check("mid.busy", 8'(bus.busy), 8'd1);
    #2 rst_n = 1'b0;
    #1;
    check_all("async_rst", 3'b000, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    send_bit(1'b0); send_bit(1'b1);
    check("post_rst.valid", 8'(bus.valid), 8'd0);
    send_bit(1'b0);
    check_all("post_rst", 3'b010, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
